// File: rtl/aq_spsram_2048x32_ctrl_pkg.sv
// Shared definitions for the 2048x32 single-port SRAM request controller.
// Widths here are also the defaults used by the IFU/LSU users of the macro.
package aq_spsram_2048x32_ctrl_pkg;

  localparam int SRAM_AW = 11;
  localparam int SRAM_DW = 32;
  localparam int SRAM_BW = SRAM_DW / 8;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/aq_spsram_2048x32_ctrl_if.sv
// Request/response handshake bundle between a requester and the SRAM controller.
// master = requester side, slave = controller side.
interface aq_spsram_2048x32_ctrl_if;
  import aq_spsram_2048x32_ctrl_pkg::*;

  logic               req_vld;
  logic               req_rdy;
  logic               req_wr;
  logic [SRAM_AW-1:0] req_addr;
  logic [SRAM_DW-1:0] req_wdata;
  logic [SRAM_BW-1:0] req_be;
  logic               rsp_vld;
  logic               rsp_rdy;
  logic [SRAM_DW-1:0] rsp_rdata;

  modport master (
    output req_vld,
    output req_wr,
    output req_addr,
    output req_wdata,
    output req_be,
    output rsp_rdy,
    input  req_rdy,
    input  rsp_vld,
    input  rsp_rdata
  );

  modport slave (
    input  req_vld,
    input  req_wr,
    input  req_addr,
    input  req_wdata,
    input  req_be,
    input  rsp_rdy,
    output req_rdy,
    output rsp_vld,
    output rsp_rdata
  );

endinterface

// File: rtl/aq_spsram_2048x32_ctrl.sv
// Request-side controller for the 2048x32 single-port SRAM macro:
// request stream -> macro pins, read response with hold buffer, clear sweep.
module aq_spsram_2048x32_ctrl
  import aq_spsram_2048x32_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH    = SRAM_AW,
  parameter int DATA_WIDTH    = SRAM_DW,
  parameter int INIT_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  aq_spsram_2048x32_ctrl_if.slave bus,
  input  logic                  init_req,
  output logic                  init_busy,
  output logic [ADDR_WIDTH-1:0] A,
  output logic                  CEN,
  output logic                  GWEN,
  output logic [DATA_WIDTH-1:0] WEN,
  output logic [DATA_WIDTH-1:0] D,
  input  logic [DATA_WIDTH-1:0] Q
);

  localparam state_e RST_ST =
    (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  state_e                state;
  state_e                state_nxt;
  logic [ADDR_WIDTH-1:0] init_ptr;
  logic [ADDR_WIDTH-1:0] init_ptr_nxt;
  logic                  rd_inflight;
  logic                  hold_vld;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [DATA_WIDTH-1:0] be_mask;
  logic                  req_rdy;
  logic                  acc;
  logic                  acc_rd;
  logic                  acc_wr;
  logic                  sweep;

  // No accept or sweep write while reset is held
  assign req_rdy = ~RST
                 & (state == ST_RUN)
                 & ~init_req
                 & ~hold_vld
                 & (~rd_inflight | bus.rsp_rdy);

  assign acc    = bus.req_vld & req_rdy;
  assign acc_rd = acc & ~bus.req_wr;
  assign acc_wr = acc & bus.req_wr & (|bus.req_be);
  assign sweep  = ~RST & (state == ST_INIT);

  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_wen
    assign be_mask[g] = ~bus.req_be[g/8];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= RST_ST;
      init_ptr <= '0;
    end else begin
      state    <= state_nxt;
      init_ptr <= init_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    init_ptr_nxt = init_ptr;
    unique case (state)
      ST_INIT: begin
        init_ptr_nxt = init_ptr + 1'b1;
        if (init_ptr == LAST) begin
          state_nxt    = ST_RUN;
          init_ptr_nxt = '0;
        end
      end
      ST_RUN: begin
        if (init_req) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (~rd_inflight & ~hold_vld) begin
          state_nxt    = ST_INIT;
          init_ptr_nxt = '0;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    A    = '0;
    CEN  = 1'b1;
    GWEN = 1'b1;
    WEN  = '1;
    D    = '0;
    unique case (1'b1)
      sweep: begin
        A    = init_ptr;
        CEN  = 1'b0;
        GWEN = 1'b0;
        WEN  = '0;
        D    = INIT_VALUE;
      end
      acc_rd: begin
        A   = bus.req_addr;
        CEN = 1'b0;
      end
      acc_wr: begin
        A    = bus.req_addr;
        CEN  = 1'b0;
        GWEN = 1'b0;
        WEN  = be_mask;
        D    = bus.req_wdata;
      end
      default: ;
    endcase
  end

  // Q is only valid the cycle after a read; park it if unaccepted
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_inflight <= 1'b0;
      hold_vld    <= 1'b0;
      hold_data   <= '0;
    end else begin
      rd_inflight <= acc_rd;
      if (hold_vld) begin
        if (bus.rsp_rdy) hold_vld <= 1'b0;
      end else if (rd_inflight & ~bus.rsp_rdy) begin
        hold_vld  <= 1'b1;
        hold_data <= Q;
      end
    end
  end

  assign bus.req_rdy   = req_rdy;
  assign bus.rsp_vld   = hold_vld | rd_inflight;
  assign bus.rsp_rdata = hold_vld ? hold_data : Q;
  assign init_busy     = (state != ST_RUN);

endmodule

// File: tb/tb_aq_spsram_2048x32_ctrl.sv
// Directed bench for aq_spsram_2048x32_ctrl with a behavioural SRAM macro
// and a read-data scoreboard.
module tb_aq_spsram_2048x32_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_req;
  logic        init_busy;
  logic [10:0] A;
  logic        CEN;
  logic        GWEN;
  logic [31:0] WEN;
  logic [31:0] D;
  logic [31:0] q;

  aq_spsram_2048x32_ctrl_if bus();

  aq_spsram_2048x32_ctrl #(
    .INIT_ON_RESET(1)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .bus       (bus),
    .init_req  (init_req),
    .init_busy (init_busy),
    .A         (A),
    .CEN       (CEN),
    .GWEN      (GWEN),
    .WEN       (WEN),
    .D         (D),
    .Q         (q)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [2048];
  logic        loaded = 1'b0;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 2048; i++) mem[i] <= $urandom | 32'h1;
      loaded <= 1'b1;
    end else if (!CEN) begin
      if (!GWEN) mem[A] <= (mem[A] & WEN) | (D & ~WEN);
      else       q <= mem[A];
    end
  end

  int          total = 0;
  int          bad   = 0;
  int          npop  = 0;
  logic [31:0] sb [$];
  logic [31:0] ref_mem [2048];
  logic        prev_busy = 1'b0;
  logic        acc_cen;
  logic        acc_gwen;
  logic [31:0] acc_wen;
  logic [10:0] acc_a;

  function automatic void chk(input string tag,
                              input logic [63:0] obs,
                              input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endfunction

  task automatic mon_step();
    logic [31:0] m;
    logic [31:0] e;
    if (rst) begin
      sb.delete();
      prev_busy = 1'b0;
      return;
    end
    if (prev_busy && !init_busy)
      for (int i = 0; i < 2048; i++) ref_mem[i] = 32'h0;
    prev_busy = init_busy;
    if (bus.rsp_vld && bus.rsp_rdy) begin
      npop++;
      chk("sb_level", (sb.size() > 0), 1'b1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rsp_data", bus.rsp_rdata, e);
      end
    end
    if (bus.req_vld && bus.req_rdy) begin
      if (bus.req_wr) begin
        for (int b = 0; b < 32; b++) m[b] = bus.req_be[b/8];
        ref_mem[bus.req_addr] =
          (ref_mem[bus.req_addr] & ~m) | (bus.req_wdata & m);
      end else begin
        sb.push_back(ref_mem[bus.req_addr]);
      end
    end
  endtask

  task automatic send(input logic wr, input logic [10:0] addr,
                      input logic [31:0] data, input logic [3:0] be);
    bus.req_vld   = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = data;
    bus.req_be    = be;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (bus.req_rdy) break;
    end
    chk("accept", bus.req_rdy, 1'b1);
    acc_cen  = CEN;
    acc_gwen = GWEN;
    acc_wen  = WEN;
    acc_a    = A;
    @(posedge clk);
    #1;
    bus.req_vld = 1'b0;
  endtask

  task automatic chk_sweep(input int exp_busy);
    int   n    = 0;
    int   busy = 0;
    logic ok   = 1'b1;
    for (int k = 0; k < 6000; k++) begin
      @(negedge clk);
      if (!init_busy) break;
      busy++;
      if (bus.req_rdy) ok = 1'b0;
      if (!CEN) begin
        if (A !== n[10:0] || GWEN !== 1'b0 ||
            WEN !== 32'h0 || D !== 32'h0) ok = 1'b0;
        n++;
      end else if (n != 0) begin
        ok = 1'b0;
      end
    end
    chk("sweep_pins", ok, 1'b1);
    chk("sweep_writes", n, 2048);
    if (exp_busy > 0) chk("sweep_busy", busy, exp_busy);
    chk("run_rdy", bus.req_rdy, 1'b1);
  endtask

  initial begin
    int p0;
    rst           = 1'b1;
    init_req      = 1'b0;
    bus.req_vld   = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    bus.rsp_rdy   = 1'b1;
    for (int i = 0; i < 2048; i++) ref_mem[i] = 32'h0;
    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", bus.req_rdy, 1'b0);
    chk("rst_cen", CEN, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", init_busy, 1'b1);
    chk("rst_rspv", bus.rsp_vld, 1'b0);
    chk("rst_wen", WEN, 32'hFFFF_FFFF);
    chk_sweep(2048);
    @(posedge clk);
    #1;

    send(1'b1, 11'h005, 32'hA5A5_A5A5, 4'hF);
    send(1'b1, 11'h005, 32'h1122_3344, 4'b0101);
    chk("t2_wen", acc_wen, 32'hFF00_FF00);
    chk("t2_gwen", acc_gwen, 1'b0);
    send(1'b1, 11'h005, 32'hFFFF_FFFF, 4'h0);
    chk("t2_nop_cen", acc_cen, 1'b1);
    send(1'b0, 11'h005, 32'h0, 4'h0);
    chk("t2_rd_a", acc_a, 11'h005);
    chk("t2_rd_gwen", acc_gwen, 1'b1);
    @(negedge clk);
    chk("t2_rspv", bus.rsp_vld, 1'b1);
    chk("t2_rdata", bus.rsp_rdata, 32'hA522_A544);
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++)
      send(1'b1, 11'(i), 32'h0101_0101 * (i + 3), 4'hF);
    p0 = npop;
    bus.req_vld = 1'b1;
    bus.req_wr  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.req_addr = 11'(i);
      @(negedge clk);
      chk("t3_rdy", bus.req_rdy, 1'b1);
      if (i > 0) chk("t3_rspv", bus.rsp_vld, 1'b1);
      @(posedge clk);
      #1;
    end
    bus.req_vld = 1'b0;
    @(negedge clk);
    chk("t3_rspv_last", bus.rsp_vld, 1'b1);
    @(negedge clk);
    chk("t3_rspv_end", bus.rsp_vld, 1'b0);
    chk("t3_pops", npop - p0, 8);
    @(posedge clk);
    #1;

    send(1'b1, 11'h020, 32'h1234_5678, 4'hF);
    send(1'b0, 11'h020, 32'h0, 4'h0);
    send(1'b1, 11'h020, 32'h0000_0009, 4'hF);
    send(1'b0, 11'h020, 32'h0, 4'h0);
    @(posedge clk);
    #1;

    send(1'b1, 11'h030, 32'hCAFE_F00D, 4'hF);
    bus.rsp_rdy = 1'b0;
    send(1'b0, 11'h030, 32'h0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_rspv", bus.rsp_vld, 1'b1);
      chk("t4_data", bus.rsp_rdata, 32'hCAFE_F00D);
      chk("t4_rdy", bus.req_rdy, 1'b0);
    end
    @(posedge clk);
    #1 bus.rsp_rdy = 1'b1;
    send(1'b1, 11'h030, 32'h0BAD_BEEF, 4'hF);
    send(1'b0, 11'h030, 32'h0, 4'h0);
    @(negedge clk);
    chk("t4_new", bus.rsp_rdata, 32'h0BAD_BEEF);
    @(posedge clk);
    #1;

    send(1'b1, 11'h009, 32'hDEAD_BEEF, 4'hF);
    bus.rsp_rdy = 1'b0;
    send(1'b0, 11'h009, 32'h0, 4'h0);
    init_req = 1'b1;
    bus.req_vld  = 1'b1;
    bus.req_wr   = 1'b1;
    bus.req_be   = 4'hF;
    @(negedge clk);
    chk("t5_pulse_rdy", bus.req_rdy, 1'b0);
    @(posedge clk);
    #1;
    init_req    = 1'b0;
    bus.req_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_drain_busy", init_busy, 1'b1);
      chk("t5_drain_cen", CEN, 1'b1);
      chk("t5_drain_rsp", bus.rsp_rdata, 32'hDEAD_BEEF);
    end
    @(posedge clk);
    #1 bus.rsp_rdy = 1'b1;
    chk_sweep(0);
    @(posedge clk);
    #1;
    send(1'b0, 11'h009, 32'h0, 4'h0);
    @(negedge clk);
    chk("t5_clr9", bus.rsp_rdata, 32'h0);
    @(posedge clk);
    #1;
    send(1'b0, 11'h030, 32'h0, 4'h0);
    @(negedge clk);
    chk("t5_clr30", bus.rsp_rdata, 32'h0);
    @(posedge clk);
    #1;

    send(1'b1, 11'h044, 32'h5555_AAAA, 4'hF);
    bus.rsp_rdy = 1'b0;
    send(1'b0, 11'h044, 32'h0, 4'h0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_rspv", bus.rsp_vld, 1'b0);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    bus.rsp_rdy = 1'b1;
    chk_sweep(2048);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (!CEN && A == 11'd999) break;
    end
    chk("t6_reach", A, 11'd999);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_cen", CEN, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;
    chk_sweep(2048);
    @(posedge clk);
    #1;
    send(1'b0, 11'h044, 32'h0, 4'h0);
    @(negedge clk);
    chk("t6_clr44", bus.rsp_rdata, 32'h0);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
